gray_mem_arb: RTL and testbench

GRAY_MEM_ARB -- requirements
Module: gray_mem_arb

---
 rtl/gray_mem_arb.sv | 172 +++++++++++++++++
 tb/tb_gray_mem_arb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_mem_arb.sv
// Two-requester read arbiter for the gray image memory, round robin with burst limit.
// Latency: read issued combinationally in the granted cycle; rvalid/rdata one cycle later.
// Backpressure: gray_ready low stalls the issue; grant and burst count hold, never forcing a switch.
// Optional: define GRAY_ARB_FIXED_PRIO_EN to replace round robin with fixed priority (m0 wins).
module gray_mem_arb #(
  parameter int AW        = 14,
  parameter int DW        = 8,
  parameter int MAX_BURST = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic          gray_ready,
  input  logic [DW-1:0] gray_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  state_t     state, state_nxt;
  logic [3:0] burst_cnt, burst_cnt_nxt;
  // 0: m0 was served most recently, 1: m1 was
  logic       last_m1, last_m1_nxt;
  logic       issue;
  logic       issue_m0;
  logic       issue_m1;
  logic       release_gnt;
  logic [3:0] burst_inc;

  assign m0_gnt   = (state == GNT0);
  assign m1_gnt   = (state == GNT1);
  assign issue_m0 = m0_gnt && m0_req && gray_ready;
  assign issue_m1 = m1_gnt && m1_req && gray_ready;
  assign issue    = issue_m0 || issue_m1;
  assign gray_req = issue;
  assign burst_inc = burst_cnt + 4'd1;

  // Read data is simply the memory bus; rvalid qualifies which requester owns it.
  assign m0_rdata = gray_data;
  assign m1_rdata = gray_data;

  // Memory address follows whichever requester holds the grant.
  always_comb begin
    gray_addr = '0;
    if (m0_gnt) begin
      gray_addr = m0_addr;
    end else if (m1_gnt) begin
      gray_addr = m1_addr;
    end
  end

  // Arbitration: next grant, burst counter and last-served tracking.
  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    last_m1_nxt   = last_m1;
    release_gnt   = 1'b0;

    if (issue) begin
      last_m1_nxt = issue_m1;
    end

    unique case (state)
      IDLE: begin
        burst_cnt_nxt = '0;
        if (m0_req && m1_req) begin
`ifdef GRAY_ARB_FIXED_PRIO_EN
          state_nxt = GNT0;
`else
          state_nxt = last_m1 ? GNT0 : GNT1;
`endif
        end else if (m0_req) begin
          state_nxt = GNT0;
        end else if (m1_req) begin
          state_nxt = GNT1;
        end
      end

      GNT0: begin
        // A stall (no issue) never reaches the burst limit, so the grant holds.
        release_gnt = !m0_req || (issue_m0 && (burst_inc == BURST_LIM));
        if (issue_m0) begin
          burst_cnt_nxt = burst_inc;
        end
        if (release_gnt) begin
          burst_cnt_nxt = '0;
`ifdef GRAY_ARB_FIXED_PRIO_EN
          if (m0_req) begin
            state_nxt = GNT0;
          end else if (m1_req) begin
            state_nxt = GNT1;
          end else begin
            state_nxt = IDLE;
          end
`else
          if (m1_req) begin
            state_nxt = GNT1;
          end else if (m0_req) begin
            state_nxt = GNT0;
          end else begin
            state_nxt = IDLE;
          end
`endif
        end
      end

      GNT1: begin
        release_gnt = !m1_req || (issue_m1 && (burst_inc == BURST_LIM));
        if (issue_m1) begin
          burst_cnt_nxt = burst_inc;
        end
        if (release_gnt) begin
          burst_cnt_nxt = '0;
          // m0 is the "other" side here in both modes, so it wins either way.
          if (m0_req) begin
            state_nxt = GNT0;
          end else if (m1_req) begin
            state_nxt = GNT1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  // Arbiter state registers; reset leaves m1 as last served so m0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last_m1   <= 1'b1;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      last_m1   <= last_m1_nxt;
    end
  end

  // Read-valid pipeline: one cycle after issue; reset drops anything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= issue_m0;
      m1_rvalid <= issue_m1;
    end
  end

endmodule

// File: tb/tb_gray_mem_arb.sv
// Scoreboard bench for gray_mem_arb: a rule-level arbiter model predicts grants and issues.
// Expected read returns are queued at issue time and popped by an independent monitor.
// Directed scenarios (single, contention, stall, early release, reset) then random traffic.
module tb_gray_mem_arb;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int MB = 9;

  logic          clk;
  logic          reset;
  logic          m0_req, m1_req;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_gnt, m1_gnt;
  logic          m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic          gray_ready;
  logic [DW-1:0] gray_data;

  gray_mem_arb #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr),
    .m1_req(m1_req), .m1_addr(m1_addr),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .gray_req(gray_req), .gray_addr(gray_addr),
    .gray_ready(gray_ready), .gray_data(gray_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            who;
    logic [DW-1:0] dat;
    int            stamp;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Memory contents seen by the bench: a fixed scramble of the address.
  function automatic logic [DW-1:0] dat_of(input logic [AW-1:0] a);
    int v;
    v = int'(a) * 37 + (int'(a) >> 5) + 3;
    return DW'(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: who holds the grant (-1 none), issues in this grant, last served.
  int            owner;
  int            used;
  int            last;
  logic          pend_vld;
  logic [AW-1:0] pend_addr;
  int            issues_m0, issues_m1;

  task automatic model_reset();
    owner = -1;
    used  = 0;
    last  = 1;
  endtask

  // One clock cycle: drive inputs after the edge, check and step the model at negedge.
  task automatic run_cycle(input logic r0, input logic [AW-1:0] a0,
                           input logic r1, input logic [AW-1:0] a1, input logic rdy);
    logic          req[2];
    logic [AW-1:0] adr[2];
    logic          iss;
    logic          done;
    int            other;
    int            nxt;
    @(posedge clk);
    #1;
    cyc++;
    gray_data = pend_vld ? dat_of(pend_addr) : DW'($urandom);
    pend_vld  = 1'b0;
    m0_req = r0; m0_addr = a0; m1_req = r1; m1_addr = a1; gray_ready = rdy;
    @(negedge clk);
    req[0] = r0; req[1] = r1; adr[0] = a0; adr[1] = a1;
    check("m0_gnt", int'(m0_gnt), int'(owner == 0));
    check("m1_gnt", int'(m1_gnt), int'(owner == 1));
    iss = (owner >= 0) && req[owner] && rdy;
    check("gray_req", int'(gray_req), int'(iss));
    if (iss) begin
      check("gray_addr", int'(gray_addr), int'(adr[owner]));
      q.push_back('{who: owner, dat: dat_of(adr[owner]), stamp: cyc});
      pend_vld  = 1'b1;
      pend_addr = adr[owner];
      if (owner == 0) issues_m0++; else issues_m1++;
    end else if (owner < 0) begin
      check("gray_addr_idle", int'(gray_addr), 0);
    end
    // Next grant from the arbitration rules.
    if (owner < 0) begin
      used = 0;
`ifdef GRAY_ARB_FIXED_PRIO_EN
      nxt = r0 ? 0 : (r1 ? 1 : -1);
`else
      if (r0 && r1) nxt = (last == 1) ? 0 : 1;
      else          nxt = r0 ? 0 : (r1 ? 1 : -1);
`endif
    end else begin
      nxt  = owner;
      done = !req[owner];
      if (iss) begin
        used++;
        last = owner;
        if (used == MB) done = 1'b1;
      end
      if (done) begin
        used  = 0;
        other = 1 - owner;
`ifdef GRAY_ARB_FIXED_PRIO_EN
        nxt = r0 ? 0 : (r1 ? 1 : -1);
`else
        nxt = req[other] ? other : (req[owner] ? owner : -1);
`endif
      end
    end
    owner = nxt;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m0_gnt"}, int'(m0_gnt), 0);
    check({tag, "_m1_gnt"}, int'(m1_gnt), 0);
    check({tag, "_gray_req"}, int'(gray_req), 0);
    check({tag, "_gray_addr"}, int'(gray_addr), 0);
    check({tag, "_m0_rvalid"}, int'(m0_rvalid), 0);
    check({tag, "_m1_rvalid"}, int'(m1_rvalid), 0);
  endtask

  // Asynchronous reset pulse launched at a negedge; in-flight reads are discarded.
  task automatic pulse_reset();
    reset  = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    q.delete();
    pend_vld = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: every rvalid must match the oldest queued read issued the cycle before.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        if (m0_rvalid && m1_rvalid) check("rvalid_onehot", 2, 1);
        if (q.size() > 0 && q[0].stamp < cyc) begin
          e = q.pop_front();
          if (e.who == 0) begin
            check("m0_rvalid", int'(m0_rvalid), 1);
            check("m1_rvalid_off", int'(m1_rvalid), 0);
            check("m0_rdata", int'(m0_rdata), int'(e.dat));
          end else begin
            check("m1_rvalid", int'(m1_rvalid), 1);
            check("m0_rvalid_off", int'(m0_rvalid), 0);
            check("m1_rdata", int'(m1_rdata), int'(e.dat));
          end
        end else begin
          if (m0_rvalid) check("m0_rvalid_spurious", 1, 0);
          if (m1_rvalid) check("m1_rvalid_spurious", 1, 0);
        end
      end
    end
  end

  int m0_before, m1_before;

  initial begin
    reset = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_addr = '0; m1_addr = '0;
    gray_ready = 1'b1; gray_data = '0;
    pend_vld = 1'b0; pend_addr = '0;
    issues_m0 = 0; issues_m1 = 0;
    model_reset();
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b1;

    // Single requester: addresses 129, 0, 1 back to back.
    run_cycle(1'b1, 14'd129, 1'b0, '0, 1'b1);
    run_cycle(1'b1, 14'd129, 1'b0, '0, 1'b1);
    run_cycle(1'b1, 14'd0,   1'b0, '0, 1'b1);
    run_cycle(1'b1, 14'd1,   1'b0, '0, 1'b1);
    idle_cycles(3);

    // Contention: both hold requests; bursts of MB alternate with no gap.
    m0_before = issues_m0; m1_before = issues_m1;
    for (int i = 0; i < 4 * MB + 1; i++)
      run_cycle(1'b1, AW'($urandom), 1'b1, AW'($urandom), 1'b1);
`ifdef GRAY_ARB_FIXED_PRIO_EN
    check("contention_m1_issues", issues_m1 - m1_before, 0);
`else
    check("contention_m0_issues", issues_m0 - m0_before, 2 * MB);
    check("contention_m1_issues", issues_m1 - m1_before, 2 * MB);
`endif
    idle_cycles(3);

    // Stall mid-burst of m1: same address held while gray_ready is low.
    run_cycle(1'b0, '0, 1'b1, 14'd100, 1'b1);
    run_cycle(1'b0, '0, 1'b1, 14'd101, 1'b1);
    run_cycle(1'b0, '0, 1'b1, 14'd102, 1'b1);
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 14'd7, 1'b1, 14'd103, 1'b0);
    run_cycle(1'b1, 14'd7, 1'b1, 14'd103, 1'b1);
    run_cycle(1'b0, '0, 1'b1, 14'd104, 1'b1);
    idle_cycles(3);

    // Early release: m0 drops after two reads while m1 waits.
    run_cycle(1'b1, 14'd200, 1'b0, '0, 1'b1);
    run_cycle(1'b1, 14'd200, 1'b1, 14'd300, 1'b1);
    run_cycle(1'b1, 14'd201, 1'b1, 14'd300, 1'b1);
    run_cycle(1'b0, '0, 1'b1, 14'd300, 1'b1);
    run_cycle(1'b0, '0, 1'b1, 14'd301, 1'b1);
    idle_cycles(3);

    // Reset right after an issue; m0 must win the first tie afterwards.
    run_cycle(1'b0, '0, 1'b1, 14'd500, 1'b1);
    run_cycle(1'b0, '0, 1'b1, 14'd501, 1'b1);
    pulse_reset();
    run_cycle(1'b1, 14'd600, 1'b1, 14'd700, 1'b1);
    run_cycle(1'b1, 14'd601, 1'b1, 14'd701, 1'b1);
    check("post_reset_m0_wins", int'(m0_gnt), 1);
    idle_cycles(3);

    // Random traffic with varied request density and memory backpressure.
    for (int i = 0; i < 3000; i++) begin
      run_cycle(($urandom_range(0, 99) < 70), AW'($urandom),
                ($urandom_range(0, 99) < 60), AW'($urandom),
                ($urandom_range(0, 99) < 80));
    end
    idle_cycles(4);
    check("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
